// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - shifter Start/Done initiator: frame collection, timeout supervision, frame/overrun tracking
module shift_sequencer #(
    parameter int FRAME_LEN = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Enable,
    input  logic                         SampleValid,
    output logic                         Start,
    input  logic                         Done,
    output logic                         Busy,
    output logic [$clog2(FRAME_LEN)-1:0] SampleIdx,
    output logic [7:0]                   FrameCount,
    output logic                         TimeoutErr,
    output logic                         Overrun
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [TMR_W-1:0] LAST_TMR = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_REQ,
        S_WAIT
    } state_t;

    state_t           state, state_next;
    logic [TMR_W-1:0] timer, timer_next;
    logic [IDX_W-1:0] idx_next;
    logic [7:0]       count_next;
    logic             terr_next;
    logic             ovr_next;
    logic             start_next;
    logic             busy_next;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            SampleIdx  <= '0;
            FrameCount <= '0;
            TimeoutErr <= 1'b0;
            Overrun    <= 1'b0;
            Start      <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            SampleIdx  <= idx_next;
            FrameCount <= count_next;
            TimeoutErr <= terr_next;
            Overrun    <= ovr_next;
            Start      <= start_next;
            Busy       <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        idx_next   = SampleIdx;
        count_next = FrameCount;
        terr_next  = TimeoutErr;
        ovr_next   = Overrun;

        case (state)
            S_IDLE: begin
                idx_next = '0;
                if (Enable) begin
                    state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                // A frame-completing sample wins over Enable falling in the same cycle.
                if (SampleValid && SampleIdx == LAST_IDX) begin
                    idx_next   = '0;
                    state_next = S_REQ;
                end else if (!Enable) begin
                    idx_next   = '0;
                    state_next = S_IDLE;
                end else if (SampleValid) begin
                    idx_next = SampleIdx + 1'b1;
                end
            end
            S_REQ: begin
                if (SampleValid) begin
                    ovr_next = 1'b1;
                end
                timer_next = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (SampleValid) begin
                    ovr_next = 1'b1;
                end
                if (Done) begin
                    count_next = FrameCount + 8'd1;
                    state_next = Enable ? S_COLLECT : S_IDLE;
                end else if (timer == LAST_TMR) begin
                    terr_next  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Start and Busy are registered from the next state so they line up with REQ/WAIT.
        start_next = (state_next == S_REQ);
        busy_next  = (state_next == S_REQ) || (state_next == S_WAIT);
    end

endmodule
